// File: rtl/jbi_timer_tick_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Package : jbi_timer_tick_gen_pkg
//  Purpose : Shared definitions for the JBI timeout tick prescaler. The timer
//            block monitors decode the same state encodings.
//  Contents: FSM state encodings IDLE/LOAD/RUN, tick counter width and the
//            default interval loaded at reset.
//  Revision: 1.0 - initial release
// ============================================================================
package jbi_timer_tick_gen_pkg;

  // Prescaler FSM encodings. The value 2'b11 is illegal and recovers to IDLE.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;

  // Width of the wrapping debug count of issued ticks.
  localparam int TICK_CNT_W = 8;

  // An interval of 0 leaves tick generation disabled until software writes
  // a nonzero interval.
  localparam int DEF_RST_INTERVAL = 0;

endpackage
`default_nettype wire

// File: rtl/jbi_tick_dncnt.sv
`default_nettype none
// ============================================================================
//  Module  : jbi_tick_dncnt
//  Purpose : Loadable down-counter for the tick prescaler. It holds at zero,
//            and terminal flags the zero value.
//  Ports   : clk, rst      - clock, synchronous active-high reset
//            load          - load load_val (has priority over dec)
//            load_val      - value to load
//            dec           - decrement by one
//            cnt           - current count
//            terminal      - cnt == 0
//  Revision: 1.0 - initial release
// ============================================================================
module jbi_tick_dncnt
  import jbi_timer_tick_gen_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             terminal
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign terminal = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/jbi_timer_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module  : jbi_timer_tick_gen
//  Purpose : Programmable prescaler. It emits a one-cycle tick every
//            'interval' cycles, and that tick is fanned out to the per-JID
//            timeout timers.
//  Ports   : clk, rst      - clock, synchronous active-high reset
//            enable        - level, 1 = generate ticks
//            sync_restart  - pulse, restart the current period (RUN only)
//            csr_wr        - pulse, write csr_wdata into the interval register
//            csr_wdata     - new interval in cycles per tick
//            csr_interval  - programmed interval readback (unclamped)
//            tick          - registered one-cycle pulse, once per period
//            running       - 1 while the FSM is in RUN
//            tick_count    - wrapping count of issued ticks
//  Revision: 1.0 - initial release
// ============================================================================
module jbi_timer_tick_gen
  import jbi_timer_tick_gen_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int MIN_INTERVAL = 2,
  parameter int RST_INTERVAL = DEF_RST_INTERVAL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  sync_restart,
  input  logic                  csr_wr,
  input  logic [CNT_W-1:0]      csr_wdata,
  output logic [CNT_W-1:0]      csr_interval,
  output logic                  tick,
  output logic                  running,
  output logic [TICK_CNT_W-1:0] tick_count
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] eff;
  logic [CNT_W-1:0] eff_m1;
  logic             csr_zero;
  logic             cnt_load;
  logic             cnt_dec;
  logic             fire;
  logic [CNT_W-1:0] cnt;
  logic             terminal;

  // Small nonzero intervals are clamped up so that tick is never high on two
  // consecutive cycles. eff - 1 therefore cannot underflow.
  assign csr_zero = (csr_interval == '0);
  assign eff      = (csr_interval < CNT_W'(MIN_INTERVAL)) ? CNT_W'(MIN_INTERVAL)
                                                          : csr_interval;
  assign eff_m1   = eff - CNT_W'(1);

  // The RUN branch order sets the event priority. A higher-priority event in
  // the terminal cycle suppresses that cycle's tick.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    fire      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && !csr_zero) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (!enable || csr_zero) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_load  = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable || csr_zero) begin
          state_nxt = ST_IDLE;
        end else if (sync_restart) begin
          state_nxt = ST_LOAD;
        end else if (terminal) begin
          fire     = 1'b1;
          cnt_load = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  jbi_tick_dncnt #(
    .CNT_W(CNT_W)
  ) u_dncnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (eff_m1),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .terminal (terminal)
  );

  // A CSR write lands one cycle later, so any reload in the write cycle
  // still uses the previous interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      running      <= 1'b0;
      tick         <= 1'b0;
      tick_count   <= '0;
      csr_interval <= CNT_W'(RST_INTERVAL);
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == ST_RUN);
      tick    <= fire;
      if (fire) tick_count <= tick_count + TICK_CNT_W'(1);
      if (csr_wr) csr_interval <= csr_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jbi_timer_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module  : tb_jbi_timer_tick_gen
//  Purpose : Self-checking bench for jbi_timer_tick_gen. Tick cycles derived
//            from the programmed interval are queued up front and popped by
//            a monitor as ticks appear.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_jbi_timer_tick_gen;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             sync_restart;
  logic             csr_wr;
  logic [CNT_W-1:0] csr_wdata;
  logic [CNT_W-1:0] csr_interval;
  logic             tick;
  logic             running;
  logic [7:0]       tick_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_q[$];
  int mon_e;
  logic prev_tick = 1'b0;

  typedef struct {
    int interval;
    int nticks;
    int period;
  } vec_t;

  vec_t vecs[5];

  jbi_timer_tick_gen #(
    .CNT_W(CNT_W), .MIN_INTERVAL(2), .RST_INTERVAL(0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sync_restart (sync_restart),
    .csr_wr       (csr_wr),
    .csr_wdata    (csr_wdata),
    .csr_interval (csr_interval),
    .tick         (tick),
    .running      (running),
    .tick_count   (tick_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The monitor pops one expected tick cycle each time tick is seen high.
  always @(negedge clk) begin
    if (tick === 1'b1) begin
      checks++;
      if (prev_tick) begin
        failures++;
        $display("FAIL tick_back_to_back cycle=%0d", cyc);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_tick actual_cycle=%0d required=none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e != cyc) begin
          failures++;
          $display("FAIL tick_cycle actual=%0d required=%0d", cyc, mon_e);
        end
      end
    end
    prev_tick = (tick === 1'b1);
  end

  initial begin
    #400000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; sync_restart = 1'b0; csr_wr = 1'b0; csr_wdata = '0;
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Writes the interval and raises enable. The task returns in the LOAD
  // cycle, and t0 is the first RUN cycle.
  task automatic start(input int interval, output int t0);
    csr_wr = 1'b1; csr_wdata = interval;
    step();
    csr_wr = 1'b0; enable = 1'b1;
    t0 = cyc + 2;
    step();
  endtask

  task automatic finish_run(input int last, input int exp_cnt, input int exp_csr, input string tag);
    wait_until(last);
    enable = 1'b0;
    step(); step(); step();
    chk({tag, "_running_off"}, running, 0);
    chk({tag, "_missing_ticks"}, exp_q.size(), 0);
    chk({tag, "_tick_count"}, tick_count, exp_cnt);
    chk({tag, "_csr_interval"}, csr_interval, exp_csr);
    exp_q.delete();
  endtask

  initial begin
    int t0;
    vecs[0] = '{interval: 10, nticks: 3, period: 10};
    vecs[1] = '{interval: 1,  nticks: 4, period: 2};
    vecs[2] = '{interval: 2,  nticks: 3, period: 2};
    vecs[3] = '{interval: 5,  nticks: 2, period: 5};
    vecs[4] = '{interval: 3,  nticks: 3, period: 3};

    do_reset();
    chk("reset_tick", tick, 0);
    chk("reset_running", running, 0);
    chk("reset_tick_count", tick_count, 0);
    chk("reset_csr_interval", csr_interval, 0);

    // Basic periods, including the clamp of interval 1 up to period 2.
    foreach (vecs[i]) begin
      do_reset();
      start(vecs[i].interval, t0);
      for (int k = 1; k <= vecs[i].nticks; k++) exp_q.push_back(t0 + k * vecs[i].period);
      chk("load_running_low", running, 0);
      step();
      chk("t0_running_high", running, 1);
      finish_run(t0 + vecs[i].nticks * vecs[i].period, vecs[i].nticks, vecs[i].interval, "vec");
    end

    // A write in mid-period leaves the current period at 8.
    do_reset();
    start(8, t0);
    exp_q.push_back(t0 + 8); exp_q.push_back(t0 + 12); exp_q.push_back(t0 + 16);
    wait_until(t0 + 3);
    csr_wr = 1'b1; csr_wdata = 4;
    step();
    csr_wr = 1'b0;
    finish_run(t0 + 16, 3, 4, "midwrite");

    // A write in the terminal cycle: that reload still uses the old interval.
    do_reset();
    start(8, t0);
    exp_q.push_back(t0 + 8); exp_q.push_back(t0 + 16); exp_q.push_back(t0 + 20);
    wait_until(t0 + 7);
    csr_wr = 1'b1; csr_wdata = 4;
    step();
    csr_wr = 1'b0;
    finish_run(t0 + 20, 3, 4, "termwrite");

    // sync_restart in the terminal cycle suppresses the tick and passes through LOAD.
    do_reset();
    start(6, t0);
    exp_q.push_back(t0 + 13);
    wait_until(t0 + 5);
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    chk("restart_load_running", running, 0);
    step();
    chk("restart_run_running", running, 1);
    finish_run(t0 + 13, 1, 6, "restart");

    // enable drops in the terminal cycle, so no tick is emitted.
    do_reset();
    start(4, t0);
    exp_q.push_back(t0 + 4);
    wait_until(t0 + 7);
    enable = 1'b0;
    step();
    chk("disable_running", running, 0);
    finish_run(t0 + 12, 1, 4, "disable");

    // Writing 0 in the terminal cycle: the in-flight tick completes, then the FSM goes to IDLE.
    do_reset();
    start(5, t0);
    exp_q.push_back(t0 + 5);
    wait_until(t0 + 4);
    csr_wr = 1'b1; csr_wdata = 0;
    step();
    csr_wr = 1'b0;
    chk("wr0_running_still", running, 1);
    step();
    chk("wr0_running_off", running, 0);
    finish_run(t0 + 20, 1, 0, "wr0");

    // Reset mid-period aborts the period and clears every output.
    do_reset();
    start(3, t0);
    exp_q.push_back(t0 + 3); exp_q.push_back(t0 + 6);
    wait_until(t0 + 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_tick", tick, 0);
    chk("midrst_running", running, 0);
    chk("midrst_tick_count", tick_count, 0);
    chk("midrst_csr_interval", csr_interval, 0);
    finish_run(t0 + 20, 0, 0, "midrst");

    // tick_count wraps from 0xFF to 0x00.
    do_reset();
    start(2, t0);
    for (int k = 1; k <= 256; k++) exp_q.push_back(t0 + 2 * k);
    wait_until(t0 + 510);
    chk("wrap_count_ff", tick_count, 255);
    finish_run(t0 + 512, 0, 2, "wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
